// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared states, forward selects and helpers for pipeline_ctrl
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      FAULT    = 2'd2
   } pipeState_e;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   localparam logic [4:0] REG_ZERO = 5'd0;

   // EX/MEM wins over MEM/WB; r0 never forwards
   function automatic logic [1:0] fwdSel(input logic [4:0] src,
                                         input logic [4:0] memRd, input logic memRegWrite,
                                         input logic [4:0] wbRd,  input logic wbRegWrite);
      logic [1:0] sel;
      sel = FWD_RF;
      if (src != REG_ZERO) begin
         if (memRegWrite && memRd == src)     sel = FWD_EXMEM;
         else if (wbRegWrite && wbRd == src)  sel = FWD_MEMWB;
      end
      return sel;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// rtl/pipeline_ctrl_if.sv - pipeline-side signal bundle for pipeline_ctrl
interface pipeline_ctrl_if #(parameter int CNT_W = 16);
   logic [4:0]       idRs, idRt;
   logic             idUsesRt;
   logic [4:0]       exRs, exRt, exRd;
   logic             exRegWrite, exMemRead, exBranchTaken;
   logic [4:0]       memRd;
   logic             memRegWrite;
   logic [4:0]       wbRd;
   logic             wbRegWrite;
   logic             memReq, memReady;
   logic             pcWrite, ifIdWrite, exMemWrite, memWbWrite;
   logic             ifIdFlush, idExFlush, memWbFlush;
   logic [1:0]       forwardA, forwardB;
   logic             memFault;
   logic [CNT_W-1:0] stallCount;

   // controller side
   modport slave (
      input  idRs, idRt, idUsesRt, exRs, exRt, exRd, exRegWrite, exMemRead, exBranchTaken,
             memRd, memRegWrite, wbRd, wbRegWrite, memReq, memReady,
      output pcWrite, ifIdWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush, memWbFlush,
             forwardA, forwardB, memFault, stallCount
   );

   // datapath side
   modport master (
      output idRs, idRt, idUsesRt, exRs, exRt, exRd, exRegWrite, exMemRead, exBranchTaken,
             memRd, memRegWrite, wbRd, wbRegWrite, memReq, memReady,
      input  pcWrite, ifIdWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush, memWbFlush,
             forwardA, forwardB, memFault, stallCount
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - hazard stall request and forward selects (PIPE_FORWARDING_EN)
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] idRs,
   input  logic [4:0] idRt,
   input  logic       idUsesRt,
   input  logic [4:0] exRs,
   input  logic [4:0] exRt,
   input  logic [4:0] exRd,
   input  logic       exRegWrite,
   input  logic       exMemRead,
   input  logic [4:0] memRd,
   input  logic       memRegWrite,
   input  logic [4:0] wbRd,
   input  logic       wbRegWrite,
   output logic       stallReq,
   output logic [1:0] forwardA,
   output logic [1:0] forwardB
);

`ifdef PIPE_FORWARDING_EN
   // Only a load in EX cannot be forwarded in time: one bubble
   logic unusedInputs;
   assign unusedInputs = exRegWrite;

   assign stallReq = exMemRead && (exRd != REG_ZERO) &&
                     ((exRd == idRs) || (idUsesRt && exRd == idRt));
   assign forwardA = fwdSel(exRs, memRd, memRegWrite, wbRd, wbRegWrite);
   assign forwardB = fwdSel(exRt, memRd, memRegWrite, wbRd, wbRegWrite);
`else
   // No bypass network: wait until the producer reaches WB (regfile writes first half-cycle)
   logic unusedInputs;
   logic exHit, memHit;
   assign unusedInputs = ^{exRs, exRt, exMemRead, wbRd, wbRegWrite};

   assign exHit  = exRegWrite && (exRd != REG_ZERO) &&
                   ((exRd == idRs) || (idUsesRt && exRd == idRt));
   assign memHit = memRegWrite && (memRd != REG_ZERO) &&
                   ((memRd == idRs) || (idUsesRt && memRd == idRt));
   assign stallReq = exHit || memHit;
   assign forwardA = FWD_RF;
   assign forwardB = FWD_RF;
`endif

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline register sequencer: stalls, flushes, memory wait, stall counter (PIPE_FORWARDING_EN)
module pipeline_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MAX_WAIT = 15,
   parameter int CNT_W    = 16
)(
   input  logic           clock,
   input  logic           nReset,
   pipeline_ctrl_if.slave pif
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   pipeState_e        state;
   logic [WAIT_W-1:0] waitCnt;
   logic [CNT_W-1:0]  stallCount;
   logic              memFault;
   logic              stallReq;
   logic [1:0]        fwdA, fwdB;
   logic              memStall;
   logic              pcWrite, ifIdWrite, exMemWrite, memWbWrite;
   logic              ifIdFlush, idExFlush, memWbFlush;

   hazard_detect uHazard (
      .idRs        (pif.idRs),
      .idRt        (pif.idRt),
      .idUsesRt    (pif.idUsesRt),
      .exRs        (pif.exRs),
      .exRt        (pif.exRt),
      .exRd        (pif.exRd),
      .exRegWrite  (pif.exRegWrite),
      .exMemRead   (pif.exMemRead),
      .memRd       (pif.memRd),
      .memRegWrite (pif.memRegWrite),
      .wbRd        (pif.wbRd),
      .wbRegWrite  (pif.wbRegWrite),
      .stallReq    (stallReq),
      .forwardA    (fwdA),
      .forwardB    (fwdB)
   );

   // An outstanding access freezes everything, whether just issued or already waiting
   assign memStall = !pif.memReady && ((state == RUN && pif.memReq) || state == MEM_WAIT);

   // Capture/hold/bubble decisions for this cycle
   always_comb begin
      pcWrite    = 1'b1;
      ifIdWrite  = 1'b1;
      exMemWrite = 1'b1;
      memWbWrite = 1'b1;
      ifIdFlush  = 1'b0;
      idExFlush  = 1'b0;
      memWbFlush = 1'b0;
      case (state)
         RUN, MEM_WAIT: begin
            if (memStall) begin
               pcWrite    = 1'b0;
               ifIdWrite  = 1'b0;
               exMemWrite = 1'b0;
               memWbFlush = 1'b1;
            end else if (pif.exBranchTaken) begin
               // the ID instruction is discarded, so any hazard on it is moot
               ifIdFlush = 1'b1;
               idExFlush = 1'b1;
            end else if (stallReq) begin
               pcWrite   = 1'b0;
               ifIdWrite = 1'b0;
               idExFlush = 1'b1;
            end
         end
         default: begin
            pcWrite    = 1'b0;
            ifIdWrite  = 1'b0;
            exMemWrite = 1'b0;
            memWbWrite = 1'b0;
         end
      endcase
      if (!nReset) begin
         pcWrite    = 1'b0;
         ifIdWrite  = 1'b0;
         exMemWrite = 1'b0;
         memWbWrite = 1'b0;
         ifIdFlush  = 1'b1;
         idExFlush  = 1'b1;
         memWbFlush = 1'b1;
      end
   end

   // Memory-wait sequencing and timeout into the sticky fault state
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         state    <= RUN;
         waitCnt  <= '0;
         memFault <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (pif.memReq && !pif.memReady) begin
                  state   <= MEM_WAIT;
                  waitCnt <= WAIT_W'(1);
               end
            end
            MEM_WAIT: begin
               if (pif.memReady) begin
                  state   <= RUN;
                  waitCnt <= '0;
               end else if (waitCnt == WAIT_W'(MAX_WAIT)) begin
                  state    <= FAULT;
                  memFault <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + WAIT_W'(1);
               end
            end
            FAULT: state <= FAULT;
            default: state <= RUN;
         endcase
      end
   end

   // Saturating count of cycles the PC was held, excluding the fault freeze
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset)
         stallCount <= '0;
      else if (!pcWrite && state != FAULT && stallCount != '1)
         stallCount <= stallCount + CNT_W'(1);
   end

   assign pif.pcWrite    = pcWrite;
   assign pif.ifIdWrite  = ifIdWrite;
   assign pif.exMemWrite = exMemWrite;
   assign pif.memWbWrite = memWbWrite;
   assign pif.ifIdFlush  = ifIdFlush;
   assign pif.idExFlush  = idExFlush;
   assign pif.memWbFlush = memWbFlush;
   assign pif.forwardA   = nReset ? fwdA : FWD_RF;
   assign pif.forwardB   = nReset ? fwdB : FWD_RF;
   assign pif.memFault   = memFault;
   assign pif.stallCount = stallCount;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - scoreboard bench for pipeline_ctrl (PIPE_FORWARDING_EN aware)
module tb_pipeline_ctrl;

   logic clock;
   logic nReset;

   pipeline_ctrl_if #(.CNT_W(16)) pif ();

   pipeline_ctrl #(.MAX_WAIT(15), .CNT_W(16)) dut (
      .clock  (clock),
      .nReset (nReset),
      .pif    (pif.slave)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

`ifdef PIPE_FORWARDING_EN
   localparam bit FWD_ON = 1'b1;
`else
   localparam bit FWD_ON = 1'b0;
`endif

   // {pcWrite, ifIdWrite, exMemWrite, memWbWrite, ifIdFlush, idExFlush, memWbFlush, fwdA, fwdB, memFault}
   localparam logic [11:0] C_RUN = 12'b1111_000_00_00_0;
   localparam logic [11:0] C_HAZ = 12'b0011_010_00_00_0;
   localparam logic [11:0] C_MEM = 12'b0001_001_00_00_0;
   localparam logic [11:0] C_BR  = 12'b1111_110_00_00_0;
   localparam logic [11:0] C_RST = 12'b0000_111_00_00_0;
   localparam logic [11:0] C_FLT = 12'b0000_000_00_00_1;

   typedef struct {
      string       name;
      logic [11:0] ctl;
      logic [15:0] cnt;
   } expEntry_t;

   expEntry_t   sbq[$];
   int          checks;
   int          failures;
   logic [15:0] expCnt;

   logic [11:0] actCtl;
   assign actCtl = {pif.pcWrite, pif.ifIdWrite, pif.exMemWrite, pif.memWbWrite,
                    pif.ifIdFlush, pif.idExFlush, pif.memWbFlush,
                    pif.forwardA, pif.forwardB, pif.memFault};

   task automatic clearInputs();
      pif.idRs = 0; pif.idRt = 0; pif.idUsesRt = 0;
      pif.exRs = 0; pif.exRt = 0; pif.exRd = 0;
      pif.exRegWrite = 0; pif.exMemRead = 0; pif.exBranchTaken = 0;
      pif.memRd = 0; pif.memRegWrite = 0; pif.wbRd = 0; pif.wbRegWrite = 0;
      pif.memReq = 0; pif.memReady = 0;
   endtask

   // Push the expectation for the cycle just driven and advance the stall-count model
   task automatic pushExp(input string n, input logic [11:0] c, input bit inRst);
      expEntry_t x;
      x.name = n;
      x.ctl  = c;
      x.cnt  = inRst ? 16'd0 : expCnt;
      sbq.push_back(x);
      if (inRst)                                      expCnt = 16'd0;
      else if (!c[11] && !c[0] && expCnt != 16'hFFFF) expCnt = expCnt + 16'd1;
   endtask

   task automatic test_reset();
      expEntry_t e;
      clearInputs();
      nReset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) nReset = 1'b1;
         pushExp(i == 2 ? "reset_release" : "reset_hold", i == 2 ? C_RUN : C_RST, i != 2);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_load_use();
      expEntry_t e;
      string nm;
      logic [11:0] c;
      for (int i = 0; i < 6; i++) begin
         clearInputs();
         case (i)
            0: begin pif.exMemRead = 1; pif.exRegWrite = 1; pif.exRd = 5; pif.idRs = 5; nm = "loaduse_rs"; c = C_HAZ; end
            1: begin nm = "loaduse_after"; c = C_RUN; end
            2: begin pif.exMemRead = 1; pif.exRegWrite = 1; pif.exRd = 6; pif.idRs = 3; pif.idRt = 6; nm = "loaduse_rt_unused"; c = C_RUN; end
            3: begin pif.exMemRead = 1; pif.exRegWrite = 1; pif.exRd = 6; pif.idRs = 3; pif.idRt = 6; pif.idUsesRt = 1; nm = "loaduse_rt"; c = C_HAZ; end
            4: begin pif.exMemRead = 1; pif.exRegWrite = 1; pif.exRd = 0; pif.idRs = 0; pif.idRt = 0; pif.idUsesRt = 1; nm = "loaduse_r0"; c = C_RUN; end
            default: begin nm = "loaduse_idle"; c = C_RUN; end
         endcase
         pushExp(nm, c, 1'b0);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_raw_no_forwarding();
      expEntry_t e;
      for (int i = 0; i < 2; i++) begin
         clearInputs();
         if (i == 0) begin pif.exRegWrite = 1; pif.exRd = 7; pif.idRs = 7; end
         else begin pif.memRegWrite = 1; pif.memRd = 9; pif.idRt = 9; pif.idUsesRt = 1; pif.idRs = 2; end
         pushExp(i == 0 ? "raw_ex" : "raw_mem", FWD_ON ? C_RUN : C_HAZ, 1'b0);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_forwarding();
      expEntry_t e;
      logic [1:0] fa, fb;
      string nm;
      for (int i = 0; i < 4; i++) begin
         clearInputs();
         pif.memRegWrite = 1; pif.wbRegWrite = 1;
         case (i)
            0: begin pif.memRd = 8; pif.wbRd = 8; pif.exRs = 8; fa = 2'b10; fb = 2'b00; nm = "fwd_exmem"; end
            1: begin pif.memRegWrite = 0; pif.memRd = 8; pif.wbRd = 8; pif.exRs = 8; fa = 2'b01; fb = 2'b00; nm = "fwd_memwb"; end
            2: begin pif.memRd = 0; pif.wbRd = 0; pif.exRs = 0; pif.exRt = 0; fa = 2'b00; fb = 2'b00; nm = "fwd_r0"; end
            default: begin pif.memRd = 3; pif.wbRd = 4; pif.exRs = 4; pif.exRt = 3; fa = 2'b01; fb = 2'b10; nm = "fwd_both"; end
         endcase
         if (!FWD_ON) begin fa = 2'b00; fb = 2'b00; end
         pushExp(nm, {C_RUN[11:5], fa, fb, 1'b0}, 1'b0);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_mem_wait();
      expEntry_t e;
      for (int i = 0; i < 6; i++) begin
         clearInputs();
         pif.memReq   = (i < 5);
         pif.memReady = (i == 0 || i == 4);
         pushExp(i == 0 ? "mem_zero_wait" : (i < 4 ? "mem_frozen" : "mem_done"),
                 (i >= 1 && i <= 3) ? C_MEM : C_RUN, 1'b0);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_branch_hazard();
      expEntry_t e;
      for (int i = 0; i < 3; i++) begin
         clearInputs();
         if (i == 0) begin pif.exBranchTaken = 1; pif.exMemRead = 1; pif.exRegWrite = 1; pif.exRd = 5; pif.idRs = 5; end
         if (i == 1) pif.exBranchTaken = 1;
         pushExp(i == 0 ? "branch_over_hazard" : (i == 1 ? "branch_only" : "branch_after"),
                 i < 2 ? C_BR : C_RUN, 1'b0);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_timeout();
      expEntry_t e;
      clearInputs();
      pif.memReq = 1;
      for (int i = 0; i < 19; i++) begin
         pif.memReady = (i == 18);
         pushExp(i < 16 ? "timeout_wait" : "timeout_fault", i < 16 ? C_MEM : C_FLT, 1'b0);
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s cycle %0d ctl got %03h want %03h stallCount got %0d want %0d", e.name, i, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   task automatic test_reset_mid_wait();
      expEntry_t e;
      for (int i = 0; i < 5; i++) begin
         if (i < 3) begin clearInputs(); pif.memReq = 1; end
         if (i == 2) nReset = 1'b0;
         if (i == 3) begin clearInputs(); nReset = 1'b1; end
         case (i)
            0, 1:    pushExp("midwait_frozen", C_MEM, 1'b0);
            2:       pushExp("midwait_reset", C_RST, 1'b1);
            default: pushExp("midwait_release", C_RUN, 1'b0);
         endcase
         @(negedge clock);
         e = sbq.pop_front();
         checks++;
         if ({actCtl, pif.stallCount} !== {e.ctl, e.cnt}) begin
            failures++;
            $display("FAIL %s ctl got %03h want %03h stallCount got %0d want %0d", e.name, actCtl, e.ctl, pif.stallCount, e.cnt);
         end
         @(posedge clock); #1;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      expCnt   = 16'd0;
      nReset   = 1'b0;
      clearInputs();
      @(posedge clock); #1;
      test_reset();
      test_load_use();
      test_raw_no_forwarding();
      test_forwarding();
      test_mem_wait();
      test_branch_hazard();
      test_timeout();
      test_reset();
      test_reset_mid_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central sequencer for the five-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It decides every cycle whether each pipeline register captures, holds or inserts a bubble. It detects load-use and RAW hazards, flushes on taken branches, and freezes the whole pipeline while a multi-cycle data-memory access is outstanding. It also supplies operand-forwarding selects to the EX stage and keeps a saturating stall-cycle counter.

## Interface
Parameters:
- MAX_WAIT, 15: maximum cycles a memory access may stay outstanding before fault.
- CNT_W, 16: width of stallCount.

Ports:
- clock  in  1  pipeline clock, rising edge.
- nReset  in  1  asynchronous, active-low reset.
- idRs, idRt  in  5 each  source registers of the instruction in ID.
- idUsesRt  in  1  the ID instruction reads rt.
- exRs, exRt  in  5 each  source registers of the instruction in EX.
- exRd  in  5  destination of the instruction in EX.
- exRegWrite, exMemRead  in  1 each  EX instruction writes a register / is a load.
- exBranchTaken  in  1  branch or jump resolved taken in EX.
- memRd  in  5  destination held in EX/MEM.
- memRegWrite  in  1  EX/MEM instruction writes a register.
- wbRd  in  5  destination held in MEM/WB.
- wbRegWrite  in  1  MEM/WB instruction writes a register.
- memReq, memReady  in  1 each  data-memory access issued in MEM / access completes this cycle.
- pcWrite, ifIdWrite, exMemWrite, memWbWrite  out  1 each  register capture enables.
- ifIdFlush, idExFlush, memWbFlush  out  1 each  load a bubble (all control bits 0).
- forwardA, forwardB  out  2 each  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB data.
- memFault  out  1  sticky memory-timeout flag.
- stallCount  out  CNT_W  saturating count of cycles with pcWrite=0.

## Operation
- States: RUN, MEM_WAIT, FAULT. State, wait counter, stallCount and memFault are registered. All other outputs are combinational from state and inputs.
- Register 0 never creates a hazard or a forward.

RUN:
- Default: all write enables 1, all flushes 0.
- Memory stall:
  - If memReq=1 and memReady=0: freeze the pipeline (pcWrite=ifIdWrite=exMemWrite=0, idExFlush=0) and set memWbFlush=1 with memWbWrite=1.
  - Next state is MEM_WAIT and the wait counter loads 1.
- Hazard stall (only when there is no memory stall):
  - Effect: pcWrite=0, ifIdWrite=0, idExFlush=1.
  - Hazard condition: the EX instruction is a load and its rd equals idRs, or equals idRt with idUsesRt=1. Without the configuration macro the condition is wider (see Configuration).
- Branch flush (only when there is no memory stall): ifIdFlush=1, idExFlush=1, pcWrite=1.
  - A branch overrides a simultaneous hazard stall, because the ID instruction is discarded.

MEM_WAIT:
- Outputs match the RUN memory-stall outputs while memReady=0. The wait counter increments.
- When memReady=1: outputs are those of RUN for the current inputs (hazard and branch logic apply). MEM/WB captures the read data. Next state is RUN.
- If the counter equals MAX_WAIT with memReady=0: next state is FAULT.

FAULT:
- All write enables are 0, all flushes are 0 and memFault=1.
- FAULT holds until nReset is asserted.

Forwarding:
- forwardA is 10 when memRegWrite=1 and memRd=exRs. Otherwise it is 01 when wbRegWrite=1 and wbRd=exRs. Otherwise 00.
- forwardB follows the same rule on exRt.
- EX/MEM has priority over MEM/WB.

stallCount:
- Increments on every clock edge where pcWrite=0 and the state is not FAULT.
- Saturates at all-ones.

## Timing
- Reset (nReset low, asynchronous):
  - State goes to RUN; wait counter, stallCount and memFault go to 0.
  - While nReset is low: all write enables 0, all flushes 1, forwardA=forwardB=00.
- A hazard stall is decided and applied in the same cycle.
- With the macro, a load-use dependency costs exactly 1 bubble.
- A memory access that is ready in the same cycle as memReq adds 0 stall cycles. An access that becomes ready after N cycles adds N stall cycles.
- Reset asserted during MEM_WAIT abandons the access. There is no replay.

## Configuration
PIPE_FORWARDING_EN.

Defined:
- Forwarding logic is present.
- A hazard stall occurs only on load-use, as described above.

Undefined:
- forwardA and forwardB are tied to 00.
- A hazard stall occurs whenever idRs (or idRt with idUsesRt=1) matches exRd with exRegWrite=1, or memRd with memRegWrite=1.
- A dependency on EX costs 2 bubbles; a dependency on MEM costs 1. The register file writes in the first half of the cycle.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, FAULT);
  - the forward-select constants FWD_RF=00, FWD_EXMEM=10, FWD_MEMWB=01;
  - the zero-register constant.
- One sub-module, hazard_detect: purely combinational. It takes the register-compare inputs and produces the stall request and forward selects. It contains the PIPE_FORWARDING_EN conditional.

## Test plan
- Load-use (macro defined): exMemRead=1, exRegWrite=1, exRd=5, idRs=5 -> one cycle with pcWrite=0, ifIdWrite=0, idExFlush=1; stallCount goes 0->1.
- Forwarding: memRegWrite=1, memRd=8, wbRegWrite=1, wbRd=8, exRs=8 -> forwardA=10. With memRegWrite=0 -> forwardA=01. With exRs=0 and all matching rd=0 -> forwardA=00.
- Memory wait: memReq=1, memReady low for 3 cycles then high -> 3 frozen cycles with memWbFlush=1, RUN on the 4th cycle, stallCount=3.
- Timeout: memReq=1, memReady never asserted, MAX_WAIT=15 -> FAULT after 15 wait cycles; memFault=1 and all enables 0 until reset.
- Branch plus hazard: exBranchTaken=1 together with a load-use match -> pcWrite=1, ifIdFlush=1, idExFlush=1, no stall.
- Reset during MEM_WAIT: drop nReset mid-access -> flushes immediately 1, state RUN and stallCount=0 after release.
